ar_arbiter: RTL and testbench
=============================

Name: ar_arbiter

Overview:
- Read-address channel arbiter for one slave port of the crossbar.
- Selects one of NUM_MASTERS AR requesters round-robin, registers the winning request and issues it to the slave.
- On each slave handshake, pushes the issued request into the slave-port pending-read FIFO. Response routing uses that FIFO.
- Limits in-flight reads with an outstanding counter and the FIFO full flag.

Parameters:
NUM_MASTERS, 2, number of requesting master ports (>=2)
ID_WIDTH, 4, master-side ARID width
ADDR_WIDTH, 32, address width
LEN_WIDTH, 4, burst length width
SIZE_WIDTH, 3, burst size width
MAX_OUTSTANDING, 4, maximum issued-but-uncompleted read bursts
(derived) MIDX_W = $clog2(NUM_MASTERS); CNT_W = $clog2(MAX_OUTSTANDING+1)

Ports:
ACLK  in  1  clock, all state on rising edge
ARESETn  in  1  asynchronous active-low reset
M_ARID  in  NUM_MASTERS*ID_WIDTH  packed per-master ARID, master i at slice i
M_ARADDR  in  NUM_MASTERS*ADDR_WIDTH  packed addresses
M_ARLEN  in  NUM_MASTERS*LEN_WIDTH  packed lengths
M_ARSIZE  in  NUM_MASTERS*SIZE_WIDTH  packed sizes
M_ARBURST  in  NUM_MASTERS*2  packed burst types
M_ARVALID  in  NUM_MASTERS  per-master request valid
M_ARREADY  out  NUM_MASTERS  per-master accept, one-hot or zero
S_ARID  out  ID_WIDTH+MIDX_W  {master index, master ARID}
S_ARADDR / S_ARLEN / S_ARSIZE / S_ARBURST  out  as master fields  issued request
S_ARVALID  out  1  slave request valid
S_ARREADY  in  1  slave accept
fifo_push  out  1  push issued request (S_* fields) into pending FIFO
fifo_full  in  1  pending FIFO full
rd_done  in  1  one read burst completed (RLAST handshake) this cycle
outstanding  out  CNT_W  current in-flight count
grant_idx  out  MIDX_W  index of last granted master

Behaviour:
- Reset (ARESETn=0, asynchronous) clears all of the following:
  - state returns to IDLE and the round-robin pointer rr_ptr to 0;
  - outstanding=0 and grant_idx=0;
  - all S_* output registers go to 0, with S_ARVALID=0;
  - M_ARREADY=0 and fifo_push=0.
  - Reset mid-transaction drops the held request silently.
- FSM has two states, IDLE and SEND.
- IDLE:
  - can_arb = ~fifo_full & (outstanding < MAX_OUTSTANDING).
  - If can_arb and any M_ARVALID, the winner g is the first asserted valid searching from rr_ptr upward with wrap at NUM_MASTERS.
  - M_ARREADY[g]=1 combinationally in that cycle. That is the master handshake.
  - At the clock edge: capture M fields[g] into the S_* registers with S_ARID={g, M_ARID[g]}; set grant_idx=g and rr_ptr=(g+1) mod NUM_MASTERS; go to SEND.
  - If not can_arb, all M_ARREADY=0 and the FSM stays in IDLE.
- SEND:
  - S_ARVALID=1 and S_* are stable. All M_ARREADY=0.
  - On S_ARREADY=1: fifo_push=1 in the same cycle (combinational, = S_ARVALID & S_ARREADY); outstanding increments at the edge; go to IDLE.
  - Without S_ARREADY, hold indefinitely.
- Latency: master handshake at cycle t gives S_ARVALID from cycle t+1. Minimum spacing is 2 cycles per grant (no back-to-back overlap).
- Outstanding counter:
  - +1 on slave handshake, -1 on rd_done.
  - Simultaneous +1 and -1 leaves the count unchanged.
  - rd_done while outstanding=0 is ignored (no underflow); an assertion flags it.
- fifo_full is sampled only in IDLE. Only this block pushes, so a FIFO not full at grant remains pushable at issue.
- A master that drops M_ARVALID before being granted is simply skipped. This is AXI-illegal; an assertion checks it.

Decomposition:
- Shared package xbar_pkg holds:
  - burst-type constants (FIXED=2'b00, INCR=2'b01, WRAP=2'b10);
  - an ar_req_t struct (id, addr, len, size, burst), parameterised widths fixed by package localparams;
  - state enum {IDLE, SEND}.
- One natural sub-module, rr_arbiter: NUM_MASTERS requests, rr_ptr, and an update enable in; one-hot grant and index out. It is reused by the AW channel.

Test Plan:
- Single master 0 requests ARADDR=0x1000, LEN=3, S_ARREADY=1 -> M_ARREADY[0] in cycle t; S_ARVALID and fifo_push in t+1; S_ARID={0,ID}; outstanding=1.
- Both masters continuously valid, S_ARREADY=1 -> grants alternate 0,1,0,1; grant_idx sequence matches; one grant every 2 cycles.
- MAX_OUTSTANDING=4, no rd_done, 6 requests -> exactly 4 issued and outstanding=4; then one rd_done -> fifth issues.
- fifo_full=1 with M_ARVALID=1 -> no M_ARREADY, no push; fifo_full drops -> grant next cycle.
- S_ARREADY held low 5 cycles in SEND -> S_* stable and no push; on S_ARREADY with rd_done the same cycle -> outstanding unchanged.
- ARESETn asserted while in SEND -> S_ARVALID=0 and outstanding=0 immediately (asynchronous); rd_done at outstanding=0 leaves the count at 0.

Source files
------------

// File: rtl/xbar_pkg.sv
// xbar_pkg: shared crossbar types, burst encodings and channel FSM states
package xbar_pkg;

    localparam int AR_ID_W   = 4;
    localparam int AR_ADDR_W = 32;
    localparam int AR_LEN_W  = 4;
    localparam int AR_SIZE_W = 3;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;

    typedef struct packed {
        logic [AR_ID_W-1:0]   id;
        logic [AR_ADDR_W-1:0] addr;
        logic [AR_LEN_W-1:0]  len;
        logic [AR_SIZE_W-1:0] size;
        logic [1:0]           burst;
    } ar_req_t;

    typedef enum logic {IDLE, SEND} state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of the first request at or above ptr, wrapping
module rr_arbiter #(
    parameter int N = 2,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         en,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         valid
);

    // scan from ptr upward; the first hit wins and masks later candidates
    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (en && !valid && req[(int'(ptr) + k) % N]) begin
                valid                     = 1'b1;
                gnt[(int'(ptr) + k) % N]  = 1'b1;
                idx                       = W'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/ar_arbiter.sv
// ar_arbiter: round-robin AR channel arbiter for one slave port with in-flight limit
module ar_arbiter
    import xbar_pkg::*;
#(
    parameter int NUM_MASTERS     = 2,
    parameter int ID_WIDTH        = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int LEN_WIDTH       = 4,
    parameter int SIZE_WIDTH      = 3,
    parameter int MAX_OUTSTANDING = 4,
    localparam int MIDX_W = $clog2(NUM_MASTERS),
    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                              ACLK,
    input  logic                              ARESETn,
    input  logic [NUM_MASTERS*ID_WIDTH-1:0]   M_ARID,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] M_ARADDR,
    input  logic [NUM_MASTERS*LEN_WIDTH-1:0]  M_ARLEN,
    input  logic [NUM_MASTERS*SIZE_WIDTH-1:0] M_ARSIZE,
    input  logic [NUM_MASTERS*2-1:0]          M_ARBURST,
    input  logic [NUM_MASTERS-1:0]            M_ARVALID,
    output logic [NUM_MASTERS-1:0]            M_ARREADY,
    output logic [ID_WIDTH+MIDX_W-1:0]        S_ARID,
    output logic [ADDR_WIDTH-1:0]             S_ARADDR,
    output logic [LEN_WIDTH-1:0]              S_ARLEN,
    output logic [SIZE_WIDTH-1:0]             S_ARSIZE,
    output logic [1:0]                        S_ARBURST,
    output logic                              S_ARVALID,
    input  logic                              S_ARREADY,
    output logic                              fifo_push,
    input  logic                              fifo_full,
    input  logic                              rd_done,
    output logic [CNT_W-1:0]                  outstanding,
    output logic [MIDX_W-1:0]                 grant_idx
);

    state_t            state, state_nx;
    logic [MIDX_W-1:0] rr_ptr, win_idx;
    logic              win, can_arb, dec;

    assign can_arb   = ~fifo_full & (outstanding < CNT_W'(MAX_OUTSTANDING));
    assign S_ARVALID = (state == SEND);
    assign fifo_push = S_ARVALID & S_ARREADY;
    assign dec       = rd_done & (outstanding != '0);

    // reset gates the grant so M_ARREADY is low while ARESETn is asserted
    rr_arbiter #(.N(NUM_MASTERS)) u_rr (
        .req   (M_ARVALID),
        .ptr   (rr_ptr),
        .en    (ARESETn & (state == IDLE) & can_arb),
        .gnt   (M_ARREADY),
        .idx   (win_idx),
        .valid (win)
    );

    // state register
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state <= IDLE;
        else          state <= state_nx;
    end

    // grant moves to SEND, slave handshake returns to IDLE
    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE) ? (win ? SEND : IDLE) : (S_ARREADY ? IDLE : SEND);
    end

    // capture the winner, advance the pointer and track reads in flight
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            S_ARID      <= '0;
            S_ARADDR    <= '0;
            S_ARLEN     <= '0;
            S_ARSIZE    <= '0;
            S_ARBURST   <= '0;
            grant_idx   <= '0;
            rr_ptr      <= '0;
            outstanding <= '0;
        end else begin
            if (win) begin
                S_ARID    <= {win_idx, M_ARID[win_idx*ID_WIDTH +: ID_WIDTH]};
                S_ARADDR  <= M_ARADDR[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                S_ARLEN   <= M_ARLEN[win_idx*LEN_WIDTH +: LEN_WIDTH];
                S_ARSIZE  <= M_ARSIZE[win_idx*SIZE_WIDTH +: SIZE_WIDTH];
                S_ARBURST <= M_ARBURST[win_idx*2 +: 2];
                grant_idx <= win_idx;
                rr_ptr    <= (win_idx == MIDX_W'(NUM_MASTERS - 1)) ? '0 : win_idx + 1'b1;
            end
            if (fifo_push != dec) outstanding <= fifo_push ? outstanding + 1'b1 : outstanding - 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_hold
        a_hold: assert property (@(posedge ACLK) disable iff (!ARESETn)
            M_ARVALID[i] && !M_ARREADY[i] |=> M_ARVALID[i])
            else $error("master %0d dropped ARVALID before grant", i);
    end

    a_underflow: assert property (@(posedge ACLK) disable iff (!ARESETn)
        rd_done |-> outstanding != '0)
        else $warning("rd_done with no read in flight ignored");

endmodule

// File: tb/tb_ar_arbiter.sv
// tb_ar_arbiter: directed scenario checks for the AR channel arbiter
module tb_ar_arbiter;
    import xbar_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic [7:0]  M_ARID = '0;
    logic [63:0] M_ARADDR = '0;
    logic [7:0]  M_ARLEN = '0;
    logic [5:0]  M_ARSIZE = '0;
    logic [3:0]  M_ARBURST = '0;
    logic [1:0]  M_ARVALID = '0;
    logic [1:0]  M_ARREADY;
    logic [4:0]  S_ARID;
    logic [31:0] S_ARADDR;
    logic [3:0]  S_ARLEN;
    logic [2:0]  S_ARSIZE;
    logic [1:0]  S_ARBURST;
    logic        S_ARVALID;
    logic        S_ARREADY = 1'b0;
    logic        fifo_push;
    logic        fifo_full = 1'b0;
    logic        rd_done = 1'b0;
    logic [2:0]  outstanding;
    logic        grant_idx;

    int vectors = 0;
    int miscompares = 0;

    always #5 ACLK = ~ACLK;

    ar_arbiter dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .M_ARID(M_ARID), .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN),
        .M_ARSIZE(M_ARSIZE), .M_ARBURST(M_ARBURST),
        .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .S_ARID(S_ARID), .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN),
        .S_ARSIZE(S_ARSIZE), .S_ARBURST(S_ARBURST),
        .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
        .fifo_push(fifo_push), .fifo_full(fifo_full), .rd_done(rd_done),
        .outstanding(outstanding), .grant_idx(grant_idx)
    );

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic set_master(input int m, input logic [3:0] id, input logic [31:0] addr,
                              input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
        M_ARID[m*4 +: 4]     = id;
        M_ARADDR[m*32 +: 32] = addr;
        M_ARLEN[m*4 +: 4]    = len;
        M_ARSIZE[m*3 +: 3]   = size;
        M_ARBURST[m*2 +: 2]  = burst;
    endtask

    task automatic do_reset();
        M_ARVALID = '0;
        S_ARREADY = 1'b0;
        fifo_full = 1'b0;
        rd_done   = 1'b0;
        ARESETn   = 1'b0;
        step();
        step();
        ARESETn = 1'b1;
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        #3;
        vectors++; if (S_ARVALID !== 1'b0) begin miscompares++; $display("FAIL reset_svalid got=%b exp=0", S_ARVALID); end
        vectors++; if (outstanding !== 3'd0) begin miscompares++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
        vectors++; if (grant_idx !== 1'b0) begin miscompares++; $display("FAIL reset_grant_idx got=%b exp=0", grant_idx); end
        vectors++; if (M_ARREADY !== 2'b00) begin miscompares++; $display("FAIL reset_mready got=%b exp=00", M_ARREADY); end
        vectors++; if (fifo_push !== 1'b0) begin miscompares++; $display("FAIL reset_push got=%b exp=0", fifo_push); end
        vectors++; if (S_ARADDR !== 32'h0) begin miscompares++; $display("FAIL reset_saddr got=%h exp=0", S_ARADDR); end
        vectors++; if (S_ARID !== 5'h0) begin miscompares++; $display("FAIL reset_sid got=%h exp=0", S_ARID); end
        step();
        ARESETn = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        set_master(0, 4'h5, 32'h1000, 4'd3, 3'd2, INCR);
        set_master(1, 4'hA, 32'h2000, 4'd1, 3'd2, INCR);
        S_ARREADY = 1'b1;
        M_ARVALID = 2'b01;
        #1;
        vectors++; if (M_ARREADY !== 2'b01) begin miscompares++; $display("FAIL single_mready got=%b exp=01", M_ARREADY); end
        vectors++; if (S_ARVALID !== 1'b0) begin miscompares++; $display("FAIL single_svalid_early got=%b exp=0", S_ARVALID); end
        step();
        M_ARVALID = 2'b00;
        #1;
        vectors++; if (S_ARVALID !== 1'b1) begin miscompares++; $display("FAIL single_svalid got=%b exp=1", S_ARVALID); end
        vectors++; if (fifo_push !== 1'b1) begin miscompares++; $display("FAIL single_push got=%b exp=1", fifo_push); end
        vectors++; if (S_ARID !== 5'h05) begin miscompares++; $display("FAIL single_sid got=%h exp=05", S_ARID); end
        vectors++; if (S_ARADDR !== 32'h1000) begin miscompares++; $display("FAIL single_saddr got=%h exp=1000", S_ARADDR); end
        vectors++; if (S_ARLEN !== 4'd3) begin miscompares++; $display("FAIL single_slen got=%0d exp=3", S_ARLEN); end
        vectors++; if (S_ARSIZE !== 3'd2) begin miscompares++; $display("FAIL single_ssize got=%0d exp=2", S_ARSIZE); end
        vectors++; if (S_ARBURST !== INCR) begin miscompares++; $display("FAIL single_sburst got=%b exp=01", S_ARBURST); end
        vectors++; if (M_ARREADY !== 2'b00) begin miscompares++; $display("FAIL single_mready_send got=%b exp=00", M_ARREADY); end
        step();
        #1;
        vectors++; if (outstanding !== 3'd1) begin miscompares++; $display("FAIL single_outstanding got=%0d exp=1", outstanding); end
        vectors++; if (S_ARVALID !== 1'b0) begin miscompares++; $display("FAIL single_idle got=%b exp=0", S_ARVALID); end
    endtask

    task automatic test_back_to_back();
        logic       exp;
        logic [4:0] eid;
        logic [31:0] eaddr;
        do_reset();
        S_ARREADY = 1'b1;
        M_ARVALID = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp   = (k % 2 == 1);
            eid   = exp ? 5'h1A : 5'h05;
            eaddr = exp ? 32'h2000 : 32'h1000;
            #1;
            vectors++; if (M_ARREADY !== (exp ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL b2b_mready[%0d] got=%b exp_idx=%0d", k, M_ARREADY, exp); end
            step();
            #1;
            vectors++; if (S_ARVALID !== 1'b1 || fifo_push !== 1'b1) begin miscompares++; $display("FAIL b2b_issue[%0d] got=%b%b exp=11", k, S_ARVALID, fifo_push); end
            vectors++; if (grant_idx !== exp) begin miscompares++; $display("FAIL b2b_grant_idx[%0d] got=%b exp=%b", k, grant_idx, exp); end
            vectors++; if (S_ARID !== eid) begin miscompares++; $display("FAIL b2b_sid[%0d] got=%h exp=%h", k, S_ARID, eid); end
            vectors++; if (S_ARADDR !== eaddr) begin miscompares++; $display("FAIL b2b_saddr[%0d] got=%h exp=%h", k, S_ARADDR, eaddr); end
            vectors++; if (M_ARREADY !== 2'b00) begin miscompares++; $display("FAIL b2b_gap[%0d] got=%b exp=00", k, M_ARREADY); end
            step();
        end
        #1;
        vectors++; if (outstanding !== 3'd4) begin miscompares++; $display("FAIL max_outstanding got=%0d exp=4", outstanding); end
        for (int k = 0; k < 3; k++) begin
            vectors++; if (M_ARREADY !== 2'b00 || S_ARVALID !== 1'b0) begin miscompares++; $display("FAIL max_block[%0d] got=%b/%b exp=00/0", k, M_ARREADY, S_ARVALID); end
            step();
            #1;
        end
        rd_done = 1'b1;
        #1;
        vectors++; if (M_ARREADY !== 2'b00) begin miscompares++; $display("FAIL max_rd_same got=%b exp=00", M_ARREADY); end
        step();
        rd_done = 1'b0;
        #1;
        vectors++; if (outstanding !== 3'd3) begin miscompares++; $display("FAIL max_after_done got=%0d exp=3", outstanding); end
        vectors++; if (M_ARREADY !== 2'b01) begin miscompares++; $display("FAIL max_fifth_mready got=%b exp=01", M_ARREADY); end
        step();
        #1;
        vectors++; if (S_ARADDR !== 32'h1000 || grant_idx !== 1'b0) begin miscompares++; $display("FAIL max_fifth_issue got=%h/%b exp=1000/0", S_ARADDR, grant_idx); end
        step();
        #1;
        vectors++; if (outstanding !== 3'd4) begin miscompares++; $display("FAIL max_refill got=%0d exp=4", outstanding); end
    endtask

    task automatic test_fifo_full();
        do_reset();
        fifo_full = 1'b1;
        S_ARREADY = 1'b1;
        M_ARVALID = 2'b01;
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++; if (M_ARREADY !== 2'b00 || fifo_push !== 1'b0) begin miscompares++; $display("FAIL full_block[%0d] got=%b/%b exp=00/0", k, M_ARREADY, fifo_push); end
            step();
        end
        fifo_full = 1'b0;
        #1;
        vectors++; if (M_ARREADY !== 2'b01) begin miscompares++; $display("FAIL full_release got=%b exp=01", M_ARREADY); end
        step();
        M_ARVALID = 2'b00;
        #1;
        vectors++; if (fifo_push !== 1'b1) begin miscompares++; $display("FAIL full_push got=%b exp=1", fifo_push); end
        step();
        #1;
        vectors++; if (outstanding !== 3'd1) begin miscompares++; $display("FAIL full_outstanding got=%0d exp=1", outstanding); end
    endtask

    task automatic test_stall();
        do_reset();
        S_ARREADY = 1'b1;
        M_ARVALID = 2'b01;
        step();
        M_ARVALID = 2'b00;
        step();
        set_master(1, 4'h3, 32'h3000, 4'd7, 3'd1, WRAP);
        S_ARREADY = 1'b0;
        M_ARVALID = 2'b10;
        #1;
        vectors++; if (M_ARREADY !== 2'b10) begin miscompares++; $display("FAIL stall_mready got=%b exp=10", M_ARREADY); end
        step();
        M_ARVALID = 2'b00;
        for (int k = 0; k < 5; k++) begin
            #1;
            vectors++; if (S_ARVALID !== 1'b1 || fifo_push !== 1'b0) begin miscompares++; $display("FAIL stall_hold[%0d] got=%b/%b exp=1/0", k, S_ARVALID, fifo_push); end
            vectors++; if (S_ARADDR !== 32'h3000 || S_ARID !== 5'h13 || S_ARLEN !== 4'd7 || S_ARSIZE !== 3'd1 || S_ARBURST !== WRAP)
                begin miscompares++; $display("FAIL stall_stable[%0d] got=%h/%h/%h/%h/%b exp=3000/13/7/1/10", k, S_ARADDR, S_ARID, S_ARLEN, S_ARSIZE, S_ARBURST); end
            step();
        end
        S_ARREADY = 1'b1;
        rd_done   = 1'b1;
        #1;
        vectors++; if (fifo_push !== 1'b1) begin miscompares++; $display("FAIL stall_push got=%b exp=1", fifo_push); end
        step();
        S_ARREADY = 1'b0;
        rd_done   = 1'b0;
        #1;
        vectors++; if (outstanding !== 3'd1) begin miscompares++; $display("FAIL stall_simul got=%0d exp=1", outstanding); end
        vectors++; if (S_ARVALID !== 1'b0) begin miscompares++; $display("FAIL stall_idle got=%b exp=0", S_ARVALID); end
    endtask

    task automatic test_reset_in_send();
        do_reset();
        S_ARREADY = 1'b1;
        M_ARVALID = 2'b01;
        step();
        M_ARVALID = 2'b00;
        step();
        S_ARREADY = 1'b0;
        M_ARVALID = 2'b01;
        step();
        M_ARVALID = 2'b00;
        #1;
        vectors++; if (S_ARVALID !== 1'b1 || outstanding !== 3'd1) begin miscompares++; $display("FAIL rsend_pre got=%b/%0d exp=1/1", S_ARVALID, outstanding); end
        #2;
        ARESETn = 1'b0;
        #1;
        vectors++; if (S_ARVALID !== 1'b0) begin miscompares++; $display("FAIL rsend_svalid got=%b exp=0", S_ARVALID); end
        vectors++; if (outstanding !== 3'd0) begin miscompares++; $display("FAIL rsend_outstanding got=%0d exp=0", outstanding); end
        vectors++; if (S_ARADDR !== 32'h0) begin miscompares++; $display("FAIL rsend_saddr got=%h exp=0", S_ARADDR); end
        step();
        ARESETn = 1'b1;
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
        #1;
        vectors++; if (outstanding !== 3'd0) begin miscompares++; $display("FAIL rsend_underflow got=%0d exp=0", outstanding); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fifo_full();
        test_stall();
        test_reset_in_send();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
